// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit line RAM between two whole-line requesters.
// Optional performance counters are compiled in with `define ARB_PERF_EN.
module line_mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128,
  parameter int BE_W   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LINE_W-1:0] wdata0,
  input  logic [BE_W-1:0]   be0,
  output logic              ack0,
  output logic [LINE_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LINE_W-1:0] wdata1,
  input  logic [BE_W-1:0]   be1,
  output logic              ack1,
  output logic [LINE_W-1:0] rdata1,
`ifdef ARB_PERF_EN
  output logic [31:0]       gnt_cnt0,
  output logic [31:0]       gnt_cnt1,
  output logic [31:0]       stall_cnt,
`endif
  output logic              WE,
  output logic [BE_W-1:0]   BE,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_data_w,
  input  logic [LINE_W-1:0] ram_data_r
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                gsel_q, gsel_d;
  logic                last_q, last_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [LINE_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                grant;
  logic                g_we;

  // RAM-side outputs are registered, so they are loaded on the edge entering ACCESS.
  always_comb begin
    state_d  = state_q;
    gsel_d   = gsel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    we_d     = 1'b0;
    be_d     = '0;
    addr_d   = '0;
    wdata_d  = '0;
    grant    = 1'b0;
    g_we     = gsel_q ? we1 : we0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = (req0 && req1) ? ~last_q : req1;
          gsel_d  = grant;
          state_d = ACCESS;
          we_d    = grant ? we1    : we0;
          be_d    = grant ? be1    : be0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (g_we) begin
          state_d = RESP;
          ack0_d  = ~gsel_q;
          ack1_d  = gsel_q;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LAT - 1);
          addr_d  = addr_q;
        end
      end
      WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d  = cnt_q - 3'd1;
          addr_d = addr_q;
        end else begin
          if (gsel_q) rdata1_d = ram_data_r;
          else        rdata0_d = ram_data_r;
          state_d = RESP;
          ack0_d  = ~gsel_q;
          ack1_d  = gsel_q;
        end
      end
      RESP: begin
        last_d  = gsel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gsel_q   <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gsel_q   <= gsel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign WE         = we_q;
  assign BE         = be_q;
  assign ram_addr   = addr_q;
  assign ram_data_w = wdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d, stall_cnt_q, stall_cnt_d;
  logic        stall;

  always_comb begin
    stall = (req0 && (gsel_q != 1'b0 || state_q != IDLE)) ||
            (req1 && (gsel_q != 1'b1 || state_q != IDLE));
    gnt_cnt0_d  = gnt_cnt0_q + {31'd0, ack0_q};
    gnt_cnt1_d  = gnt_cnt1_q + {31'd0, ack1_q};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0_q  <= '0;
      gnt_cnt1_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      gnt_cnt0_q  <= gnt_cnt0_d;
      gnt_cnt1_q  <= gnt_cnt1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign gnt_cnt0  = gnt_cnt0_q;
  assign gnt_cnt1  = gnt_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
